// File: rtl/approx_mac_seq_if.sv
// Operand stream, multiplier issue/return bus and result port of approx_mac_seq.
// master = sequencer side, slave = environment (operand source, multiplier, result sink).
interface approx_mac_seq_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 24,
  parameter int LEN_W = 8,
  parameter int COLS  = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 mul_en;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [COLS-1:0]      comp_en;
  logic [2*WIDTH-1:0]   mul_p;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_acc;
  logic [LEN_W-1:0]     out_cnt;

  modport master (
    input  in_valid, in_a, in_b, mul_p, out_ready,
    output in_ready, mul_en, mul_a, mul_b, comp_en, out_valid, out_acc, out_cnt
  );

  modport slave (
    output in_valid, in_a, in_b, mul_p, out_ready,
    input  in_ready, mul_en, mul_a, mul_b, comp_en, out_valid, out_acc, out_cnt
  );
endinterface

// File: rtl/approx_mac_seq.sv
// Job sequencer for the approximate MAC: issues operand pairs, gates compressor columns,
// accumulates returned products. Optional macro ACC_SAT_EN: saturating accumulator + out_ovf.
module approx_mac_seq #(
  parameter int WIDTH   = 8,
  parameter int ACC_W   = 24,
  parameter int LEN_W   = 8,
  parameter int MUL_LAT = 2,
  parameter int COLS    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [LEN_W-1:0] cfg_apx,
  output logic             busy,
`ifdef ACC_SAT_EN
  output logic             out_ovf,
`endif
  approx_mac_seq_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [LEN_W-1:0]     len;
  logic [LEN_W-1:0]     issued;
  logic [LEN_W-1:0]     retired;
  logic [COLS-1:0]      mask;
  logic [COLS-1:0]      cfg_mask;
  logic [ACC_W-1:0]     acc;
  logic [MUL_LAT-1:0]   inflight;
  logic                 hs;
  logic                 ret;
  logic [ACC_W:0]       sum;

  // Thermometer mask; columns at or above cfg_apx stay exact, which also clips to COLS.
  always_comb begin
    cfg_mask = '0;
    for (int unsigned i = 0; i < COLS; i++)
      cfg_mask[i] = (32'(cfg_apx) > i);
  end

  assign bus.in_ready = (state == RUN) && (issued < len);
  assign hs           = bus.in_valid && bus.in_ready;
  assign ret          = inflight[MUL_LAT-1];
  assign sum          = {1'b0, acc} + (ACC_W+1)'(bus.mul_p);
  assign busy         = (state != IDLE);
  assign bus.out_acc  = acc;
  assign bus.out_cnt  = retired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      len           <= '0;
      issued        <= '0;
      retired       <= '0;
      mask          <= '0;
      acc           <= '0;
      inflight      <= '0;
      bus.mul_en    <= 1'b0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      bus.comp_en   <= '0;
      bus.out_valid <= 1'b0;
`ifdef ACC_SAT_EN
      out_ovf       <= 1'b0;
`endif
    end else begin
      bus.mul_en  <= hs;
      bus.comp_en <= hs ? mask : '0;
      if (hs) begin
        bus.mul_a <= bus.in_a;
        bus.mul_b <= bus.in_b;
        issued    <= issued + 1'b1;
      end

      inflight[0] <= bus.mul_en;
      for (int unsigned i = 1; i < MUL_LAT; i++)
        inflight[i] <= inflight[i-1];

      if (ret) begin
        retired <= retired + 1'b1;
`ifdef ACC_SAT_EN
        if (sum[ACC_W]) begin
          acc     <= '1;
          out_ovf <= 1'b1;
        end else begin
          acc <= sum[ACC_W-1:0];
        end
`else
        acc <= sum[ACC_W-1:0];
`endif
      end

      case (state)
        IDLE: begin
          if (start) begin
            len     <= cfg_len;
            mask    <= cfg_mask;
            acc     <= '0;
            issued  <= '0;
            retired <= '0;
`ifdef ACC_SAT_EN
            out_ovf <= 1'b0;
`endif
            if (cfg_len == '0) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (hs && (issued == len - 1'b1))
            state <= DRAIN;
        end
        DRAIN: begin
          // Last product retires this cycle, so the result is final on entering DONE.
          if (ret && (retired == len - 1'b1)) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mac_seq.sv
// Directed bench for approx_mac_seq with an exact-multiplier stand-in and a job-level
// scoreboard checked every cycle. Honours ACC_SAT_EN when defined.
module tb_approx_mac_seq;
  localparam int WIDTH   = 8;
  localparam int ACC_W   = 16;
  localparam int LEN_W   = 8;
  localparam int MUL_LAT = 2;
  localparam int COLS    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [LEN_W-1:0] cfg_apx = '0;
  logic             busy;
`ifdef ACC_SAT_EN
  logic             out_ovf;
`endif

  approx_mac_seq_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .LEN_W(LEN_W), .COLS(COLS)) dif ();

  approx_mac_seq #(.WIDTH(WIDTH), .ACC_W(ACC_W), .LEN_W(LEN_W), .MUL_LAT(MUL_LAT), .COLS(COLS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cfg_len (cfg_len),
    .cfg_apx (cfg_apx),
    .busy    (busy),
`ifdef ACC_SAT_EN
    .out_ovf (out_ovf),
`endif
    .bus     (dif)
  );

  always #5 clk = ~clk;

  // Exact multiplier with MUL_LAT pipeline; junk on idle slots so stray accumulation shows.
  logic [2*WIDTH-1:0] p_pipe [MUL_LAT];
  always @(posedge clk) begin
    p_pipe[0] <= dif.mul_en ? (16'(dif.mul_a) * 16'(dif.mul_b)) : 16'hA5A5;
    for (int i = 1; i < MUL_LAT; i++) p_pipe[i] <= p_pipe[i-1];
  end
  assign dif.mul_p = p_pipe[MUL_LAT-1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level scoreboard state
  bit          armed = 1'b0;
  bit          exp_en = 1'b0;
  logic [7:0]  exp_a = '0, exp_b = '0;
  logic [15:0] m_mask = '0;
  int          m_len = 0, m_acc = 0, m_cnt = 0;
  longint      m_sum = 0;
  bit          m_active = 1'b0;
`ifdef ACC_SAT_EN
  bit          m_ovf = 1'b0;
`endif
  int          n_en = 0;
  logic [15:0] last_ce = '0;

  always @(negedge clk) begin
    longint p;
    if (armed) begin
      chk("mul_en", dif.mul_en, exp_en);
      chk("mul_a", dif.mul_a, exp_a);
      chk("mul_b", dif.mul_b, exp_b);
      chk("comp_en", dif.comp_en, exp_en ? m_mask : 16'h0);
      chk("in_ready", dif.in_ready, m_active && (m_acc < m_len));
      chk("busy", busy, m_active);
      if (dif.out_valid) begin
        chk("out_acc", dif.out_acc, m_sum);
        chk("out_cnt", dif.out_cnt, m_cnt);
`ifdef ACC_SAT_EN
        chk("out_ovf", out_ovf, m_ovf);
`endif
      end
      if (dif.mul_en) begin
        n_en++;
        last_ce = dif.comp_en;
      end
    end
    if (rst) begin
      armed = 1'b1; exp_en = 1'b0; exp_a = '0; exp_b = '0;
      m_active = 1'b0; m_sum = 0; m_cnt = 0; m_len = 0; m_acc = 0;
`ifdef ACC_SAT_EN
      m_ovf = 1'b0;
`endif
    end else begin
      exp_en = dif.in_valid && dif.in_ready;
      if (exp_en) begin
        exp_a = dif.in_a;
        exp_b = dif.in_b;
        p = longint'(exp_a) * longint'(exp_b);
`ifdef ACC_SAT_EN
        if (m_sum + p > 65535) begin m_sum = 65535; m_ovf = 1'b1; end
        else m_sum = m_sum + p;
`else
        m_sum = (m_sum + p) % 65536;
`endif
        m_cnt++;
        m_acc++;
      end
      if (start && !busy) begin
        m_len = cfg_len; m_acc = 0; m_cnt = 0; m_sum = 0; m_active = 1'b1;
        m_mask = (cfg_apx >= 16) ? 16'hFFFF : 16'((32'd1 << cfg_apx) - 1);
`ifdef ACC_SAT_EN
        m_ovf = 1'b0;
`endif
      end else if (dif.out_valid && dif.out_ready) begin
        m_active = 1'b0;
      end
    end
  end

  int pa [16];
  int pb [16];
  int vpat [8];
  int vlen = 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int len, input int apx, input bit poke, output int lat);
    int idx = 0;
    int k = 0;
    bit h;
    start = 1'b1; cfg_len = 8'(len); cfg_apx = 8'(apx);
    tick;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 300 && lat < 0; c++) begin
      dif.in_valid = (idx < len) && (vpat[k % vlen] != 0);
      dif.in_a = 8'(pa[idx]);
      dif.in_b = 8'(pb[idx]);
      k++;
      start = poke && (c == 2);
      if (poke) cfg_len = 8'd9;
      h = dif.in_valid && dif.in_ready;
      tick;
      if (h) idx++;
      if (dif.out_valid) lat = c;
    end
    start = 1'b0;
    dif.in_valid = 1'b0;
    if (lat < 0) chk("job_timeout", 0, 1);
  endtask

  task automatic consume(input int hold, input int want_acc);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", dif.out_valid, 1);
      chk("hold_acc", dif.out_acc, want_acc);
    end
    dif.out_ready = 1'b1;
    tick;
    dif.out_ready = 1'b0;
    chk("post_valid", dif.out_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    int lat;
    int n0;
    int want;
    dif.in_valid = 1'b0; dif.in_a = '0; dif.in_b = '0; dif.out_ready = 1'b0;
    repeat (3) tick;
    rst = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_mul_en", dif.mul_en, 0);
    chk("rst_comp_en", dif.comp_en, 0);
    chk("rst_out_valid", dif.out_valid, 0);
    chk("rst_out_acc", dif.out_acc, 0);
    chk("rst_out_cnt", dif.out_cnt, 0);
    chk("rst_in_ready", dif.in_ready, 0);
`ifdef ACC_SAT_EN
    chk("rst_out_ovf", out_ovf, 0);
`endif

    // Basic job
    pa[0] = 3; pb[0] = 5; pa[1] = 7; pb[1] = 2; pa[2] = 10; pb[2] = 10; pa[3] = 255; pb[3] = 1;
    vpat[0] = 1; vlen = 1;
    n0 = n_en;
    run_job(4, 0, 1'b0, lat);
    chk("basic_lat", lat, 7);
    chk("basic_acc", dif.out_acc, 384);
    chk("basic_cnt", dif.out_cnt, 4);
    chk("basic_issues", n_en - n0, 4);
    consume(0, 384);

    // Approximate column masks
    pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4; pa[2] = 5; pb[2] = 6;
    n0 = n_en;
    run_job(3, 6, 1'b0, lat);
    chk("apx6_issues", n_en - n0, 3);
    chk("apx6_mask", last_ce, 16'h003F);
    chk("apx6_acc", dif.out_acc, 44);
    consume(0, 44);
    pa[0] = 9; pb[0] = 9; pa[1] = 2; pb[1] = 3;
    run_job(2, 40, 1'b0, lat);
    chk("apx40_mask", last_ce, 16'hFFFF);
    chk("apx40_acc", dif.out_acc, 87);
    consume(0, 87);

    // Bubbles and result backpressure
    pa[0] = 20; pb[0] = 30; pa[1] = 40; pb[1] = 50; pa[2] = 60; pb[2] = 70;
    vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 0; vpat[5] = 1; vlen = 6;
    n0 = n_en;
    run_job(3, 2, 1'b0, lat);
    chk("bubble_issues", n_en - n0, 3);
    chk("bubble_acc", dif.out_acc, 6800);
    consume(5, 6800);
    vpat[0] = 1; vlen = 1;

    // Zero length, then start poked mid-run
    n0 = n_en;
    run_job(0, 3, 1'b0, lat);
    chk("zero_lat", lat, 1);
    chk("zero_acc", dif.out_acc, 0);
    chk("zero_cnt", dif.out_cnt, 0);
    chk("zero_issues", n_en - n0, 0);
    consume(0, 0);
    pa[0] = 11; pb[0] = 12; pa[1] = 13; pb[1] = 14;
    run_job(2, 0, 1'b1, lat);
    chk("poke_cnt", dif.out_cnt, 2);
    chk("poke_acc", dif.out_acc, 314);
    consume(0, 314);

    // Reset while draining with products in flight
    start = 1'b1; cfg_len = 8'd2; cfg_apx = 8'd4;
    tick;
    start = 1'b0;
    dif.in_valid = 1'b1; dif.in_a = 8'd100; dif.in_b = 8'd200;
    tick;
    dif.in_a = 8'd50; dif.in_b = 8'd60;
    tick;
    dif.in_valid = 1'b0;
    chk("drain_busy", busy, 1);
    chk("drain_in_ready", dif.in_ready, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mul_en", dif.mul_en, 0);
    chk("mid_rst_mul_a", dif.mul_a, 0);
    chk("mid_rst_mul_b", dif.mul_b, 0);
    chk("mid_rst_comp_en", dif.comp_en, 0);
    chk("mid_rst_out_valid", dif.out_valid, 0);
    chk("mid_rst_out_acc", dif.out_acc, 0);
    chk("mid_rst_out_cnt", dif.out_cnt, 0);
    repeat (4) tick;
    pa[0] = 4; pb[0] = 4;
    run_job(1, 0, 1'b0, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_acc", dif.out_acc, 16);
    chk("post_rst_cnt", dif.out_cnt, 1);
    consume(0, 16);

    // Accumulator overflow
    pa[0] = 255; pb[0] = 255; pa[1] = 255; pb[1] = 255;
    run_job(2, 0, 1'b0, lat);
`ifdef ACC_SAT_EN
    want = 32'hFFFF;
    chk("sat_ovf", out_ovf, 1);
`else
    want = 32'hFC02;
`endif
    chk("ovf_acc", dif.out_acc, want);
    chk("ovf_cnt", dif.out_cnt, 2);
    consume(2, want);

    repeat (3) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
